// File: rtl/fp_divider_seq_if.sv
// Valid/ready handshake bundle for the sequential FP divider.
// The slave modport is the divider side; the master modport is the requester/consumer side.
interface fp_divider_seq_if #(
  parameter int TYPE = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [TYPE-1:0] in_a;
  logic [TYPE-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [TYPE-1:0] out_bits;
  logic [4:0]      except_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_bits, except_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_bits, except_flags
  );
endinterface

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 divider: restoring division, one quotient bit per clock, flush-to-zero outputs.
// Define FP_DIV_ROUND_EN for round-to-nearest-even with inexact reporting; otherwise results truncate.
module fp_divider_seq #(
  parameter int TYPE = 32
) (
  input  logic             clk,
  input  logic             rst,
  fp_divider_seq_if.slave  io
);
  localparam int EXP  = (TYPE == 16) ? 5 : 8;
  localparam int FRAC = (TYPE == 16) ? 10 : 23;
  localparam int BIAS = (1 << (EXP - 1)) - 1;
  localparam int Q    = FRAC + 3;
  localparam int CW   = $clog2(Q);
  localparam int EW   = EXP + 2;

  localparam int F_INEXACT        = 0;
  localparam int F_UNDERFLOW      = 1;
  localparam int F_OVERFLOW       = 2;
  localparam int F_DIVIDE_BY_ZERO = 3;
  localparam int F_INVALID        = 4;

`ifdef FP_DIV_ROUND_EN
  localparam logic RND = 1'b1;
`else
  localparam logic RND = 1'b0;
`endif

  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_E = EW'((1 << EXP) - 1);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic [TYPE-1:0]      QNAN   = {1'b0, {EXP{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_PACK, S_HOLD} state_e;

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic [FRAC+1:0]        rem_q, rem_d;
  logic [FRAC:0]          dvs_q, dvs_d;
  logic [Q-1:0]           quo_q, quo_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic [TYPE-1:0]        res_q, res_d;
  logic [4:0]             flg_q, flg_d;

  function automatic logic [EW-1:0] lzc(input logic [FRAC-1:0] f);
    logic [EW-1:0] n;
    n = '0;
    for (int i = 0; i < FRAC; i++)
      if (f[i]) n = EW'(FRAC - 1 - i);
    return n;
  endfunction

  logic            sa, sb;
  logic [EXP-1:0]  ea, eb;
  logic [FRAC-1:0] fa, fb;
  assign {sa, ea, fa} = io.in_a;
  assign {sb, eb, fb} = io.in_b;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign a_zero = (ea == '0) && (fa == '0);
  assign b_zero = (eb == '0) && (fb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  // Subnormals are pre-shifted so both significands carry a leading one at bit FRAC.
  logic [EW-1:0]        lza, lzb;
  logic [FRAC:0]        ma, mb;
  logic signed [EW-1:0] xa, xb;
  assign lza = lzc(fa);
  assign lzb = lzc(fb);
  assign ma  = (ea != '0) ? {1'b1, fa} : ({1'b0, fa} << (lza + EW'(1)));
  assign mb  = (eb != '0) ? {1'b1, fb} : ({1'b0, fb} << (lzb + EW'(1)));
  assign xa  = (ea != '0) ? $signed({2'b00, ea}) : -$signed(lza);
  assign xb  = (eb != '0) ? $signed({2'b00, eb}) : -$signed(lzb);

  logic                 ge, norm, guard, sticky, rup;
  logic [FRAC-1:0]      frac_p;
  logic [FRAC:0]        frac_r;
  logic signed [EW-1:0] e_p, e_r;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    res_d   = res_q;
    flg_d   = flg_q;

    ge     = rem_q >= {1'b0, dvs_q};
    // A quotient below 1.0 leaves its leading one one bit lower; take fields one place down.
    norm   = ~quo_q[Q-1];
    frac_p = norm ? quo_q[Q-3 -: FRAC] : quo_q[Q-2 -: FRAC];
    guard  = norm ? quo_q[0] : quo_q[1];
    sticky = |rem_q;
    rup    = RND & guard & (sticky | frac_p[0]);
    frac_r = {1'b0, frac_p} + {{FRAC{1'b0}}, rup};
    e_p    = norm ? (exp_q - ONE_E) : exp_q;
    e_r    = frac_r[FRAC] ? (e_p + ONE_E) : e_p;

    unique case (state_q)
      S_IDLE: if (io.in_valid) begin
        sign_d  = sa ^ sb;
        exp_d   = xa - xb + BIAS_E;
        rem_d   = {1'b0, ma};
        dvs_d   = mb;
        quo_d   = '0;
        cnt_d   = CW'(Q - 1);
        flg_d   = '0;
        state_d = S_HOLD;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          res_d = QNAN;
          flg_d[F_INVALID] = 1'b1;
        end else if (a_inf) begin
          res_d = {sa ^ sb, {EXP{1'b1}}, {FRAC{1'b0}}};
        end else if (b_zero) begin
          res_d = {sa ^ sb, {EXP{1'b1}}, {FRAC{1'b0}}};
          flg_d[F_DIVIDE_BY_ZERO] = 1'b1;
        end else if (a_zero || b_inf) begin
          res_d = {sa ^ sb, {(TYPE-1){1'b0}}};
        end else begin
          res_d   = res_q;
          flg_d   = flg_q;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = (ge ? (rem_q - {1'b0, dvs_q}) : rem_q) << 1;
        quo_d = {quo_q[Q-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_PACK;
      end
      S_PACK: begin
        flg_d = '0;
        if (e_r >= EMAX_E) begin
          res_d = {sign_q, {EXP{1'b1}}, {FRAC{1'b0}}};
          flg_d[F_OVERFLOW] = 1'b1;
          flg_d[F_INEXACT]  = RND;
        end else if (e_r <= 0) begin
          res_d = {sign_q, {(TYPE-1){1'b0}}};
          flg_d[F_UNDERFLOW] = 1'b1;
          flg_d[F_INEXACT]   = RND;
        end else begin
          res_d = {sign_q, e_r[EXP-1:0], frac_r[FRAC-1:0]};
          flg_d[F_INEXACT] = RND & (guard | sticky);
        end
        state_d = S_HOLD;
      end
      S_HOLD: if (io.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign io.in_ready     = (state_q == S_IDLE) && !rst;
  assign io.out_valid    = (state_q == S_HOLD);
  assign io.out_bits     = res_q;
  assign io.except_flags = flg_q;
endmodule

// File: tb/tb_fp_divider_seq.sv
// Bench for fp_divider_seq: single and half precision instances checked against an integer-division model.
module tb_fp_divider_seq;
  localparam int FX = 0, FU = 1, FO = 2, FZ = 3, FI = 4;
`ifdef FP_DIV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_divider_seq_if #(.TYPE(32)) i32 ();
  fp_divider_seq_if #(.TYPE(16)) i16 ();
  fp_divider_seq #(.TYPE(32)) u32 (.clk(clk), .rst(rst), .io(i32));
  fp_divider_seq #(.TYPE(16)) u16 (.clk(clk), .rst(rst), .io(i16));

  bit          hsel = 1'b0;
  logic [31:0] a_drv = '0, b_drv = '0;
  logic        v_drv = 1'b0, r_drv = 1'b0;

  assign i32.in_a      = a_drv;
  assign i32.in_b      = b_drv;
  assign i32.in_valid  = v_drv & ~hsel;
  assign i32.out_ready = r_drv & ~hsel;
  assign i16.in_a      = a_drv[15:0];
  assign i16.in_b      = b_drv[15:0];
  assign i16.in_valid  = v_drv & hsel;
  assign i16.out_ready = r_drv & hsel;

  logic        ov_s, ir_s;
  logic [31:0] ob_s;
  logic [4:0]  fl_s;
  assign ov_s = hsel ? i16.out_valid : i32.out_valid;
  assign ir_s = hsel ? i16.in_ready  : i32.in_ready;
  assign ob_s = hsel ? {16'h0, i16.out_bits} : i32.out_bits;
  assign fl_s = hsel ? i16.except_flags : i32.except_flags;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer quotient of normalized significands, then IEEE rounding/flush rules.
  function automatic void model(input bit h, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [4:0] fl, output bit sp);
    int E, F, bias, emax, xa, xb, e;
    longint unsigned ma, mb, q, rm, fr, one;
    int unsigned fa, fb, ea, eb, sgn, inf_p, zro_p;
    bit na, nb, ia, ib, za, zb, g, st;
    E = h ? 5 : 8;
    F = h ? 10 : 23;
    bias = (1 << (E - 1)) - 1;
    emax = (1 << E) - 1;
    one  = 1;
    fa = a & ((32'd1 << F) - 1);
    fb = b & ((32'd1 << F) - 1);
    ea = (a >> F) & emax;
    eb = (b >> F) & emax;
    sgn = a[E+F] ^ b[E+F];
    na = (ea == emax) && (fa != 0);  nb = (eb == emax) && (fb != 0);
    ia = (ea == emax) && (fa == 0);  ib = (eb == emax) && (fb == 0);
    za = (ea == 0) && (fa == 0);     zb = (eb == 0) && (fb == 0);
    inf_p = (sgn << (E + F)) | (emax << F);
    zro_p = sgn << (E + F);
    r = '0; fl = '0; sp = 1'b1;
    if (na || nb || (za && zb) || (ia && ib)) begin
      r = (emax << F) | (32'd1 << (F - 1)); fl[FI] = 1'b1;
    end else if (ia) begin
      r = inf_p;
    end else if (zb) begin
      r = inf_p; fl[FZ] = 1'b1;
    end else if (za || ib) begin
      r = zro_p;
    end else begin
      sp = 1'b0;
      ma = (ea != 0) ? (fa | (one << F)) : fa;  xa = (ea != 0) ? int'(ea) : 1;
      mb = (eb != 0) ? (fb | (one << F)) : fb;  xb = (eb != 0) ? int'(eb) : 1;
      while (ma < (one << F)) begin ma = ma << 1; xa--; end
      while (mb < (one << F)) begin mb = mb << 1; xb--; end
      q  = (ma << (F + 2)) / mb;
      rm = (ma << (F + 2)) % mb;
      st = (rm != 0);
      e  = xa - xb + bias;
      if (q >= (one << (F + 2))) begin st = st | q[0]; q = q >> 1; end
      else e = e - 1;
      g  = q[0];
      fr = (q >> 1) & ((one << F) - 1);
      if (RND && g && (st || fr[0])) fr = fr + 1;
      if (fr == (one << F)) begin fr = 0; e = e + 1; end
      if (e >= emax) begin
        r = inf_p; fl[FO] = 1'b1; fl[FX] = RND;
      end else if (e <= 0) begin
        r = zro_p; fl[FU] = 1'b1; fl[FX] = RND;
      end else begin
        r = (sgn << (E + F)) | (e << F) | 32'(fr);
        fl[FX] = RND && (g || st);
      end
    end
  endfunction

  function automatic logic [31:0] rnd_op(input bit h);
    int E, F, emax;
    int unsigned s, e, f;
    E = h ? 5 : 8;
    F = h ? 10 : 23;
    emax = (1 << E) - 1;
    s = $urandom_range(0, 1);
    f = $urandom & ((32'd1 << F) - 1);
    case ($urandom_range(0, 11))
      0: begin e = 0; f = 0; end
      1: begin e = emax; f = 0; end
      2: begin e = emax; if (f == 0) f = 1; end
      3, 4: e = 0;
      5: e = emax - 1 - $urandom_range(0, 3);
      6: e = 1 + $urandom_range(0, 3);
      default: e = $urandom_range(1, emax - 1);
    endcase
    return (s << (E + F)) | (e << F) | f;
  endfunction

  task automatic do_op(input bit h, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag);
    logic [31:0] er, held;
    logic [4:0]  ef;
    bit          sp;
    int          n, elat;
    model(h, a, b, er, ef, sp);
    elat = sp ? 1 : ((h ? 13 : 26) + 2);
    hsel = h;
    @(negedge clk);
    chk($sformatf("%s.in_ready", tag), {31'd0, ir_s}, 32'd1);
    a_drv = a; b_drv = b; v_drv = 1'b1;
    @(posedge clk); #1;
    v_drv = 1'b0; a_drv = $urandom; b_drv = $urandom;
    n = 1;
    @(negedge clk);
    while (!ov_s && n < 200) begin @(negedge clk); n++; end
    chk($sformatf("%s.latency", tag), n, elat);
    chk($sformatf("%s.bits", tag), ob_s, er);
    chk($sformatf("%s.flags", tag), {27'd0, fl_s}, {27'd0, ef});
    held = ob_s;
    for (int i = 0; i < hold; i++) begin
      v_drv = 1'b1; a_drv = $urandom;
      @(negedge clk);
      chk($sformatf("%s.hold_bits%0d", tag, i), ob_s, held);
      chk($sformatf("%s.hold_rdy%0d", tag, i), {31'd0, ir_s}, 32'd0);
      chk($sformatf("%s.hold_vld%0d", tag, i), {31'd0, ov_s}, 32'd1);
    end
    v_drv = 1'b0; r_drv = 1'b1;
    @(posedge clk); #1;
    r_drv = 1'b0;
    @(negedge clk);
    chk($sformatf("%s.drain", tag), {31'd0, ov_s}, 32'd0);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk("rst.rdy32", {31'd0, i32.in_ready}, 32'd0);
    chk("rst.vld32", {31'd0, i32.out_valid}, 32'd0);
    chk("rst.bits32", i32.out_bits, 32'd0);
    chk("rst.flg32", {27'd0, i32.except_flags}, 32'd0);
    chk("rst.rdy16", {31'd0, i16.in_ready}, 32'd0);
    chk("rst.bits16", {16'd0, i16.out_bits}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.release", {31'd0, i32.in_ready}, 32'd1);

    do_op(1'b0, 32'h40C00000, 32'h40000000, 0, "six_by_two");
    do_op(1'b0, 32'h3F800000, 32'h40400000, 0, "one_third");
    do_op(1'b0, 32'h3F800000, 32'h00000000, 0, "div_zero");
    do_op(1'b0, 32'h00000000, 32'h00000000, 0, "zero_zero");
    do_op(1'b0, 32'h7F800000, 32'h7F800000, 0, "inf_inf");
    do_op(1'b0, 32'hFF800000, 32'h40000000, 0, "inf_fin");
    do_op(1'b0, 32'h7F000000, 32'h3E800000, 0, "overflow");
    do_op(1'b0, 32'h00800000, 32'h40000000, 0, "underflow");
    do_op(1'b0, 32'h00200001, 32'h3F000000, 0, "subnormal_a");
    do_op(1'b0, 32'h3F800000, 32'h00400000, 0, "subnormal_b");
    do_op(1'b0, 32'h40400000, 32'h3FC00000, 5, "backpressure");

    // Abort the next operation mid-division.
    hsel = 1'b0;
    @(negedge clk);
    a_drv = 32'h40E00000; b_drv = 32'h40400000; v_drv = 1'b1;
    @(posedge clk); #1;
    v_drv = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.vld", {31'd0, i32.out_valid}, 32'd0);
    chk("abort.bits", i32.out_bits, 32'd0);
    chk("abort.flg", {27'd0, i32.except_flags}, 32'd0);
    chk("abort.rdy_in_rst", {31'd0, i32.in_ready}, 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin @(negedge clk); if (i32.out_valid) seen++; end
    chk("abort.no_stale", seen, 0);
    do_op(1'b0, 32'hC1200000, 32'h40A00000, 0, "after_abort");

    do_op(1'b1, 32'h00003C00, 32'h00004200, 0, "h_one_third");
    do_op(1'b1, 32'h00007BFF, 32'h00000001, 0, "h_overflow");

    for (int i = 0; i < 40; i++) do_op(1'b0, rnd_op(1'b0), rnd_op(1'b0), 0, $sformatf("r32_%0d", i));
    for (int i = 0; i < 30; i++) do_op(1'b1, rnd_op(1'b1), rnd_op(1'b1), 0, $sformatf("r16_%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_divider_seq.md
# fp_divider_seq

Multi-cycle IEEE-754 divider computing `in_a / in_b` by restoring long division on the significands, one quotient bit per clock. It is the sequential, general-operand companion to the combinational reciprocal unit: same field layout, the same `except_flags` encoding from `macros.vh`, and the same subnormal-output flush policy. It sits behind a valid/ready handshake in the FPU datapath and accepts one operation at a time.

## Interface
- `TYPE`, default 32: format width, 16 (half) or 32 (single); sets EXP 5/8, FRAC 10/23, BIAS 15/127.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  divider idle; accept when `in_valid && in_ready`.
- `in_a`  in  TYPE  dividend.
- `in_b`  in  TYPE  divisor.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes result.
- `out_bits`  out  TYPE  quotient.
- `except_flags`  out  5  `F_INVALID`, `F_DIVIDE_BY_ZERO`, `F_OVERFLOW`, `F_UNDERFLOW`, `F_INEXACT` bit positions from `macros.vh`.

## Operation
- States: IDLE, DIV, PACK, HOLD. `in_ready = (state == IDLE) && !rst`.
- IDLE, on accept:
  - Latch sign = sign_a XOR sign_b.
  - Normalize subnormal significands with a leading-zero shift and adjust the unbiased exponents.
  - Special operand → load result and flags, go to HOLD.
  - Otherwise load remainder = ma, divisor = mb, counter = Q−1, go to DIV.
- Special cases:
  - Either operand NaN, 0/0, or inf/inf → 0x7FC00000 (0x7E00 for half), `F_INVALID`.
  - Finite nonzero / 0 → signed inf, `F_DIVIDE_BY_ZERO`.
  - inf / finite → signed inf, no flags.
  - 0 / nonzero and finite / inf → signed zero, no flags.
- DIV: Q = FRAC+3 iterations.
  - Each cycle: if rem ≥ mb, then rem −= mb and q bit = 1, else q bit = 0.
  - Shift q left with the new bit, then rem <<= 1.
  - Counter reaches 0 → PACK.
- PACK:
  - If q[Q−1] = 0, shift q left 1 and decrement the exponent.
  - e = ea − eb + BIAS (after normalization adjusts).
  - frac = q[Q−2−:FRAC], guard = bit below frac, sticky = (rem ≠ 0).
  - Round per Configuration. A rounding carry to 2.0 → frac 0, e+1.
  - e ≥ 2^EXP−1 → signed inf, `F_OVERFLOW`.
  - e ≤ 0 → signed zero, `F_UNDERFLOW` (no subnormal outputs).
  - Register `out_bits` and `except_flags`, go to HOLD.
- HOLD:
  - `out_valid` = 1; `out_bits` and `except_flags` stay stable until `out_ready`.
  - On `out_ready` → IDLE with `out_valid` = 0 the next cycle.
  - No new accept in the same cycle (no bypass).
- Datapath widths: remainder FRAC+2 bits, quotient Q bits, exponent arithmetic signed with EXP+2 bits.

## Timing
- Reset values: state IDLE; `out_valid` = 0, `out_bits` = 0, `except_flags` = 0. `in_ready` = 0 while `rst` is high and 1 the cycle after release.
- Normal operands: `out_valid` rises Q+2 cycles after the accept edge (28 for TYPE=32, 15 for TYPE=16).
- Special operands: `out_valid` rises 1 cycle after the accept edge.
- `rst` in any state aborts the operation at the next edge, discards the result and returns all outputs to reset values.
- Operands are sampled only at accept. Input changes afterwards have no effect.

## Configuration
- `FP_DIV_ROUND_EN` defined:
  - Round to nearest even using guard and sticky.
  - `F_INEXACT` is set when guard|sticky, and also on overflow and underflow.
- `FP_DIV_ROUND_EN` undefined:
  - Truncate; guard and sticky are ignored.
  - `F_INEXACT` is never set.
  - Latency is unchanged.

## Test plan
- TYPE=32. 0x40C00000 / 0x40000000 (6/2) → 0x40400000, flags 0, `out_valid` exactly 28 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3):
  - With `FP_DIV_ROUND_EN` → 0x3EAAAAAB, `F_INEXACT`.
  - Without it → 0x3EAAAAAA, flags 0.
- Special operands, each with `out_valid` 1 cycle after accept:
  - 0x3F800000 / 0x00000000 → 0x7F800000, `F_DIVIDE_BY_ZERO`.
  - 0x00000000 / 0x00000000 → 0x7FC00000, `F_INVALID`.
- Range limits:
  - 0x7F000000 / 0x3E800000 → 0x7F800000, `F_OVERFLOW`.
  - 0x00800000 / 0x40000000 → 0x00000000, `F_UNDERFLOW`.
- Backpressure and reset:
  - Hold `out_ready` low 5 cycles in HOLD → `out_bits` stable, `in_ready` = 0.
  - Then assert `rst` mid-DIV on the next operation → `out_valid` = 0 next cycle and no stale result.
  - A following 0xC1200000 / 0x40A00000 → 0xC0000000.
- TYPE=16. 0x3C00 / 0x4200 (1/3) → 0x3555 (`FP_DIV_ROUND_EN`) or 0x3555 (truncate, flags 0), latency 15.
